// File: rtl/v_rams_pipe_arb.sv
// ----------------------------------------------------------------------------
// v_rams_pipe_arb
//   Two-requester round-robin arbiter in front of a single-port 512x4
//   pipelined distributed RAM (2-clock read latency). After reset the block
//   sweeps every RAM word to CLR_VAL (512 cycles, busy=1), then arbitrates
//   one access per cycle. Granted reads carry a {valid,id} tag down a 2-stage
//   pipeline that lines up with the RAM output, steering the return to
//   rvalid_a or rvalid_b.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   req_x/we_x/addr_x/di_x : requester A/B access (we=1 write, 0 read)
//   gnt_x               : combinational grant, transfer when req_x & gnt_x
//   rvalid_x, rdata     : read return for requester x (rdata = ram_do)
//   ram_we/ram_addr/ram_di : combinational RAM port drive
//   ram_do              : RAM read data, 2 clocks after address
//   busy                : clear sweep in progress
// ----------------------------------------------------------------------------
module v_rams_pipe_arb #(
  parameter logic [3:0] CLR_VAL = 4'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       we_a,
  input  logic       we_b,
  input  logic [8:0] addr_a,
  input  logic [8:0] addr_b,
  input  logic [3:0] di_a,
  input  logic [3:0] di_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       rvalid_a,
  output logic       rvalid_b,
  output logic [3:0] rdata,
  output logic       ram_we,
  output logic [8:0] ram_addr,
  output logic [3:0] ram_di,
  input  logic [3:0] ram_do,
  output logic       busy
);

  localparam int          AW        = 9;
  localparam int          DW        = 4;
  localparam int          STAGES    = 2;
  localparam logic [AW-1:0] LAST_ADDR = 9'h1FF;

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] di;
  } req_t;

  state_e        state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  // 1 = B wins the next contested cycle (A was granted last)
  logic          prio_b_q, prio_b_d;

  // Read tag pipeline; stage index = cycles since grant.
  logic [STAGES:1] vld_pipe_q, vld_pipe_d;
  logic [STAGES:1] id_pipe_q, id_pipe_d;

  req_t req_a_s, req_b_s, sel;
  logic any_gnt;
  logic rd_vld;
  logic rd_id;

  assign req_a_s = '{we: we_a, addr: addr_a, di: di_a};
  assign req_b_s = '{we: we_b, addr: addr_b, di: di_b};

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    prio_b_d   = prio_b_q;
    gnt_a      = 1'b0;
    gnt_b      = 1'b0;
    busy       = 1'b1;
    any_gnt    = 1'b0;
    sel        = req_a_s;
    ram_we     = 1'b0;
    ram_addr   = clr_addr_q;
    ram_di     = CLR_VAL;
    rd_vld     = 1'b0;
    rd_id      = 1'b0;

    // While rst is high the outputs hold their idle/busy defaults even if
    // the state register still says RUN (reset is only taken at the edge).
    if (!rst) begin
      unique case (state_q)
        ST_CLEAR: begin
          ram_we     = 1'b1;
          clr_addr_d = clr_addr_q + 1'b1;
          if (clr_addr_q == LAST_ADDR) state_d = ST_RUN;
        end
        ST_RUN: begin
          busy    = 1'b0;
          gnt_a   = req_a & (~req_b | ~prio_b_q);
          gnt_b   = req_b & (~req_a |  prio_b_q);
          any_gnt = gnt_a | gnt_b;
          sel     = gnt_b ? req_b_s : req_a_s;
          ram_we  = any_gnt & sel.we;
          ram_addr = sel.addr;
          ram_di   = sel.di;
          rd_vld   = any_gnt & ~sel.we;
          rd_id    = gnt_b;
          if (any_gnt) prio_b_d = gnt_a;
        end
        default: ;
      endcase
    end
  end

  // Tag shift register: stage 1 loads the grant-cycle read, stage STAGES
  // lines up with ram_do.
  always_comb begin
    vld_pipe_d = {vld_pipe_q[STAGES-1:1], rd_vld};
    id_pipe_d  = {id_pipe_q[STAGES-1:1], rd_id};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      prio_b_q   <= 1'b0;
      vld_pipe_q <= '0;
      id_pipe_q  <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      prio_b_q   <= prio_b_d;
      vld_pipe_q <= vld_pipe_d;
      id_pipe_q  <= id_pipe_d;
    end
  end

  assign rvalid_a = ~rst & vld_pipe_q[STAGES] & ~id_pipe_q[STAGES];
  assign rvalid_b = ~rst & vld_pipe_q[STAGES] &  id_pipe_q[STAGES];
  assign rdata    = (rvalid_a | rvalid_b) ? ram_do : '0;

endmodule

// File: doc/v_rams_pipe_arb.md
V_RAMS_PIPE_ARB -- requirements
Module: v_rams_pipe_arb

Interface
REQ-001 The block SHALL have parameter CLR_VAL, default 4'h0, meaning the data word written to every RAM location during the post-reset clear sweep.
REQ-002 The block SHALL have input clk, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have input rst, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have inputs req_a, req_b, 1 bit each: access request from requester A or B.
REQ-005 The block SHALL have inputs we_a, we_b, 1 bit each: 1 = write request, 0 = read request; sampled with req.
REQ-006 The block SHALL have inputs addr_a, addr_b, 9 bits each: RAM word address.
REQ-007 The block SHALL have inputs di_a, di_b, 4 bits each: write data.
REQ-008 The block SHALL have outputs gnt_a, gnt_b, 1 bit each, combinational: request accepted this cycle; transfer occurs when req_x and gnt_x are both 1.
REQ-009 The block SHALL have outputs rvalid_a, rvalid_b, 1 bit each: read data valid for that requester.
REQ-010 The block SHALL have output rdata, 4 bits: read return data, meaningful only when rvalid_a or rvalid_b is 1.
REQ-011 The block SHALL have outputs ram_we (1 bit), ram_addr (9 bits) and ram_di (4 bits), all combinational: drive the single port of the external 512x4 pipelined distributed RAM.
REQ-012 The block SHALL have input ram_do, 4 bits: RAM output, valid 2 clocks after the read address is presented.
REQ-013 The block SHALL have output busy, 1 bit: clear sweep in progress.

Function
REQ-014 FSM states SHALL be CLEAR and RUN; reset SHALL enter CLEAR with clr_addr = 0.
REQ-015 In CLEAR, each cycle the block SHALL drive ram_we=1, ram_addr=clr_addr, ram_di=CLR_VAL, and increment clr_addr; after the write to address 511 it SHALL go to RUN, making CLEAR exactly 512 cycles long.
REQ-016 In CLEAR, busy SHALL be 1 and gnt_a/gnt_b SHALL be 0; in RUN, busy SHALL be 0.
REQ-017 In RUN with exactly one requester active, that requester SHALL be granted in the same cycle.
REQ-018 In RUN with both requesters active, grant SHALL go to the requester not granted most recently (round robin); after reset, A SHALL have priority.
REQ-019 The round-robin pointer SHALL update only on a cycle with a grant; with no requests, ram_we SHALL be 0, and ram_addr/ram_di are don't-care.
REQ-020 On a granted cycle, ram_we, ram_addr and ram_di SHALL equal the granted requester's we, addr and di.
REQ-021 A granted read SHALL enter a 2-stage tag pipeline {valid, id}; rvalid_x SHALL assert exactly 2 cycles after the grant cycle, for exactly 1 cycle, with rdata = ram_do in that cycle.
REQ-022 Granted writes SHALL produce no rvalid; at most one of rvalid_a/rvalid_b SHALL be 1 in any cycle.
REQ-023 Back-to-back reads on consecutive cycles SHALL return back-to-back with no bubble; a write granted between two reads SHALL NOT disturb the in-flight read return.
REQ-024 A read of address X granted the cycle after a granted write to X SHALL return the newly written data.
REQ-025 Grant throughput SHALL be one access per cycle in RUN; there is no backpressure on read returns.

Reset
REQ-026 While rst=1: busy=1, gnt_a=gnt_b=0, rvalid_a=rvalid_b=0, tag pipeline cleared, RR pointer set to favour A, clr_addr=0, state=CLEAR.
REQ-027 rdata SHALL reset to 4'h0 if registered; if it passes ram_do through, it is don't-care while rvalid is 0.
REQ-028 Reset asserted mid-operation SHALL discard in-flight reads (no rvalid after reset) and restart the full 512-cycle clear.

Verification
REQ-029 Release reset, hold req_a=1 -> busy=1 and gnt_a=0 for 512 cycles, ram_addr stepping 0..511 with ram_di=CLR_VAL; gnt_a=1 on cycle 513.
REQ-030 After clear, A reads addr 9'h1F0 -> rvalid_a=1 exactly 2 cycles later with rdata=4'h0, then a single-cycle pulse.
REQ-031 A writes 4'hA to 9'h005, then reads 9'h005 in the next cycle -> rvalid_a with rdata=4'hA, 2 cycles after the read grant.
REQ-032 req_a=req_b=1 held for 4 cycles, all reads -> grants A,B,A,B; rvalid pattern A,B,A,B delayed by 2 cycles, never both in one cycle.
REQ-033 B read granted, then A write in the next cycle -> rvalid_b carries the pre-write contents; A's write is visible on a later read.
REQ-034 Assert rst one cycle after a read grant -> no rvalid appears; busy=1 and the sweep restarts from address 0.
